uart_tx_framed: RTL and testbench
=================================

UART_TX_FRAMED -- requirements
Module: uart_tx_framed

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50_000_000, meaning the system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115_200, meaning the line rate in bit/s.
REQ-003 The block SHALL have parameter DATA_BITS, default 8, legal 5..9, meaning payload bits per frame.
REQ-004 The block SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-005 The block SHALL have parameter STOP_BITS, default 1, legal 1..2, meaning stop bits per frame.
REQ-006 The block SHALL have parameter FIFO_DEPTH, default 4, power of two >= 2, meaning the number of queued words.
REQ-007 The block SHALL have port sys_clk, input, 1 bit, the system clock; all logic is rising-edge.
REQ-008 The block SHALL have port sys_rst_n, input, 1 bit, asynchronous active-low reset.
REQ-009 The block SHALL have port tx_data, input, DATA_BITS bits, the word to send.
REQ-010 The block SHALL have port tx_valid, input, 1 bit, which qualifies tx_data.
REQ-011 The block SHALL have port tx_ready, output, 1 bit, which is high when the FIFO can accept a word.
REQ-012 The block SHALL have port tx, output, 1 bit, the serial line; it idles high.
REQ-013 The block SHALL have port tx_busy, output, 1 bit, which is high while a frame is on the line.

Function
REQ-014 DIV SHALL equal CLK_FREQ/BAUD, truncated; elaboration SHALL fail if DIV < 2.
REQ-015 Every line bit SHALL last exactly DIV sys_clk cycles; the baud counter SHALL restart at 0 at each start bit.
REQ-016 A word SHALL be accepted on a rising edge when tx_valid and tx_ready are both high; tx_data SHALL be captured at that edge only.
REQ-017 tx_ready SHALL be the combinational inverse of FIFO full.
REQ-018 A push and a pop on the same edge SHALL leave the FIFO level unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-019 The FSM SHALL have states IDLE, START, DATA, PAR, and STOP.
REQ-020 In IDLE with the FIFO non-empty, the FSM SHALL pop the head and enter START on the same edge, driving tx low.
REQ-021 A word accepted into an empty FIFO while in IDLE SHALL produce tx low one edge after acceptance.
REQ-022 START SHALL last 1 bit; DATA SHALL last DATA_BITS bits, LSB first; PAR SHALL last 1 bit and be skipped when PARITY=0; STOP SHALL last STOP_BITS bits with tx high.
REQ-023 With odd parity (PARITY=1), the parity bit SHALL make the count of ones across data plus parity odd; with even parity (PARITY=2), it SHALL make that count even.
REQ-024 At the last cycle of STOP, the FSM SHALL go to START directly if the FIFO is non-empty (no idle gap) and to IDLE otherwise.
REQ-025 tx SHALL be driven from a register, never combinationally.
REQ-026 tx_busy SHALL be high exactly while the state is not IDLE.
REQ-027 tx_valid asserted while tx_ready is low SHALL be ignored, with no data loss inside the block.

Reset
REQ-028 While sys_rst_n is low, the outputs SHALL be tx=1, tx_busy=0, tx_ready=1, and the state SHALL be IDLE.
REQ-029 While sys_rst_n is low, the FIFO SHALL be empty and the baud and bit counters SHALL be 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously), and the queued words SHALL be discarded.
REQ-031 After reset deasserts, no partial frame SHALL resume.

Verification (CLK_FREQ=1_000_000, BAUD=100_000, so DIV=10)
REQ-032 The bench SHALL cover: 8N1, push 0x55 -> tx low 10 cycles, then 1,0,1,0,1,0,1,0 at 10 cycles each, then high 10 cycles; tx_busy high exactly 100 cycles.
REQ-033 The bench SHALL cover: PARITY=2, push 0x07 -> 9th line bit (after start) = 1; PARITY=1, push 0x07 -> that bit = 0; frame length = 110 cycles.
REQ-034 The bench SHALL cover: DATA_BITS=7, PARITY=2, STOP_BITS=2, push 0x41 -> frame of 11 bits = 110 cycles; last 20 cycles high.
REQ-035 The bench SHALL cover: FIFO_DEPTH=4, tx_valid held high for 6 consecutive cycles with distinct data -> 5 words accepted, tx_ready low from cycle 6.
REQ-036 Continuing the REQ-035 scenario, the 5 frames SHALL go out back-to-back with no idle gap and in order, and tx_ready SHALL rise one cycle after each subsequent pop.
REQ-037 The bench SHALL cover: reset asserted during data bit 3 with 2 words queued -> tx=1, tx_busy=0, tx_ready=1 immediately; no further frames after release until a new push.

Source files
------------

// File: rtl/uart_tx_framed.sv
// Framed UART transmitter: small word FIFO feeding a start/data/parity/stop serialiser.
// Line bit time is CLK_FREQ/BAUD system clocks; frames are sent back-to-back while words are queued.
module uart_tx_framed #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
    localparam int AW  = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
    localparam int BW  = 4;

    if (DIV < 2) begin : g_chk_div
        $error("uart_tx_framed: CLK_FREQ/BAUD must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
        $error("uart_tx_framed: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_chk_par
        $error("uart_tx_framed: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
        $error("uart_tx_framed: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("uart_tx_framed: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [AW:0]          r_count;

    state_t               r_state;
    logic [CW-1:0]        r_baud;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_tx;
    logic                 r_busy;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_bit_end;
    logic                 w_last_data;
    logic                 w_last_stop;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_head_par;

    assign w_full      = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_push      = tx_valid & ~w_full;
    assign w_bit_end   = (r_baud == CW'(DIV - 1));
    assign w_last_data = (r_bit == BW'(DATA_BITS - 1));
    assign w_last_stop = (r_bit == BW'(STOP_BITS - 1));
    assign w_head      = r_mem[r_rptr];
    assign w_head_par  = (PARITY == 1) ? ~(^w_head) : (^w_head);

    // The serialiser takes the head either from IDLE or at the final stop-bit cycle (no idle gap).
    assign w_pop = ~w_empty &
                   ((r_state == S_IDLE) |
                    ((r_state == S_STOP) & w_bit_end & w_last_stop));

    assign tx_ready = ~w_full;
    assign tx       = r_tx;
    assign tx_busy  = r_busy;

    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= tx_data;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_pop) begin
                r_state <= S_START;
                r_shift <= w_head;
                r_par   <= w_head_par;
                r_tx    <= 1'b0;
                r_busy  <= 1'b1;
                r_baud  <= '0;
                r_bit   <= '0;
            end
        end else if (!w_bit_end) begin
            r_baud <= r_baud + CW'(1);
        end else begin
            r_baud <= '0;
            case (r_state)
                S_START: begin
                    r_state <= S_DATA;
                    r_tx    <= r_shift[0];
                    r_bit   <= '0;
                end
                S_DATA: begin
                    if (w_last_data) begin
                        r_bit <= '0;
                        if (PARITY != 0) begin
                            r_state <= S_PAR;
                            r_tx    <= r_par;
                        end else begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_bit   <= r_bit + BW'(1);
                        r_shift <= r_shift >> 1;
                        r_tx    <= r_shift[1];
                    end
                end
                S_PAR: begin
                    r_state <= S_STOP;
                    r_tx    <= 1'b1;
                    r_bit   <= '0;
                end
                S_STOP: begin
                    if (w_last_stop) begin
                        r_bit <= '0;
                        if (w_pop) begin
                            r_state <= S_START;
                            r_shift <= w_head;
                            r_par   <= w_head_par;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_bit <= r_bit + BW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Directed bench for uart_tx_framed: four parameterisations share clock and reset,
// frames are checked bit by bit against hand-computed line patterns.
module tb_uart_tx_framed;

    localparam int DIV = 10;

    logic       sys_clk;
    logic       sys_rst_n;
    logic [8:0] tb_data  [4];
    logic       tb_valid [4];
    logic       w_tx     [4];
    logic       w_busy   [4];
    logic       w_ready  [4];

    int checks;
    int failures;

    // 0: 8N1   1: 8E1   2: 8O1   3: 7E2
    uart_tx_framed #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0),
                     .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_data(tb_data[0][7:0]),
        .tx_valid(tb_valid[0]), .tx_ready(w_ready[0]), .tx(w_tx[0]), .tx_busy(w_busy[0]));

    uart_tx_framed #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2),
                     .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_data(tb_data[1][7:0]),
        .tx_valid(tb_valid[1]), .tx_ready(w_ready[1]), .tx(w_tx[1]), .tx_busy(w_busy[1]));

    uart_tx_framed #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(1),
                     .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_data(tb_data[2][7:0]),
        .tx_valid(tb_valid[2]), .tx_ready(w_ready[2]), .tx(w_tx[2]), .tx_busy(w_busy[2]));

    uart_tx_framed #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(2),
                     .STOP_BITS(2), .FIFO_DEPTH(4)) u_7e2 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_data(tb_data[3][6:0]),
        .tx_valid(tb_valid[3]), .tx_ready(w_ready[3]), .tx(w_tx[3]), .tx_busy(w_busy[3]));

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int         dut;
        logic [8:0] data;
        int         dbits;
        int         haspar;
        logic       par;
        int         fc;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic exp_bit(input vec_t v, input int b);
        if (b == 0) return 1'b0;
        if (b <= v.dbits) return v.data[b-1];
        if (v.haspar != 0 && b == v.dbits + 1) return v.par;
        return 1'b1;
    endfunction

    // Pulse tx_valid for one edge; return at the falling edge that follows the start-bit edge.
    task automatic send(input int d, input logic [8:0] data, input string tag);
        @(negedge sys_clk);
        check({tag, " ready"}, 32'(w_ready[d]), 32'd1);
        tb_data[d]  = data;
        tb_valid[d] = 1'b1;
        @(negedge sys_clk);
        tb_valid[d] = 1'b0;
        check({tag, " pre-start tx"}, 32'(w_tx[d]), 32'd1);
        @(negedge sys_clk);
    endtask

    task automatic check_frame(input vec_t v, input int first_c, input string tag);
        logic bad [16];
        logic val [16];
        int   busy_low;
        for (int b = 0; b < 16; b++) begin
            bad[b] = 1'b0;
            val[b] = 1'bx;
        end
        busy_low = 0;
        for (int c = first_c; c < v.fc; c++) begin
            int   bi;
            logic t;
            bi = c / DIV;
            t  = w_tx[v.dut];
            if (!bad[bi]) begin
                val[bi] = t;
                if (t !== exp_bit(v, bi)) bad[bi] = 1'b1;
            end
            if (w_busy[v.dut] !== 1'b1) busy_low++;
            @(negedge sys_clk);
        end
        for (int b = first_c / DIV; b < v.fc / DIV; b++) begin
            check($sformatf("%s bit%0d", tag, b), 32'(val[b]), 32'(exp_bit(v, b)));
        end
        check({tag, " busy-low cycles"}, 32'(busy_low), 32'd0);
    endtask

    task automatic check_idle(input int d, input string tag);
        check({tag, " end busy"}, 32'(w_busy[d]), 32'd0);
        check({tag, " end tx"}, 32'(w_tx[d]), 32'd1);
    endtask

    initial begin
        vec_t v;
        int   bad_idle;
        checks   = 0;
        failures = 0;
        for (int d = 0; d < 4; d++) begin
            tb_data[d]  = '0;
            tb_valid[d] = 1'b0;
        end

        // Parity bits computed by hand from the popcount of each word.
        tbl[0] = '{0, 9'h055, 8, 0, 1'b0, 100};
        tbl[1] = '{0, 9'h0A3, 8, 0, 1'b0, 100};
        tbl[2] = '{1, 9'h007, 8, 1, 1'b1, 110};
        tbl[3] = '{2, 9'h007, 8, 1, 1'b0, 110};
        tbl[4] = '{1, 9'h0FF, 8, 1, 1'b0, 110};
        tbl[5] = '{2, 9'h000, 8, 1, 1'b1, 110};
        tbl[6] = '{3, 9'h041, 7, 1, 1'b0, 110};
        tbl[7] = '{3, 9'h07F, 7, 1, 1'b1, 110};

        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("reset dut%0d tx", d), 32'(w_tx[d]), 32'd1);
            check($sformatf("reset dut%0d busy", d), 32'(w_busy[d]), 32'd0);
            check($sformatf("reset dut%0d ready", d), 32'(w_ready[d]), 32'd1);
        end
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        for (int i = 0; i < 8; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            send(tbl[i].dut, tbl[i].data, tag);
            check_frame(tbl[i], 0, tag);
            check_idle(tbl[i].dut, tag);
            repeat (3) @(negedge sys_clk);
        end

        // Six back-to-back valids into a depth-4 FIFO while the first word is popped.
        for (int k = 1; k <= 6; k++) begin
            check($sformatf("burst ready before edge%0d", k), 32'(w_ready[0]), (k <= 5) ? 32'd1 : 32'd0);
            tb_data[0]  = 9'(k * 'h11);
            tb_valid[0] = 1'b1;
            @(negedge sys_clk);
        end
        tb_valid[0] = 1'b0;
        check("burst ready while full", 32'(w_ready[0]), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            v = '{0, 9'(k * 'h11), 8, 0, 1'b0, 100};
            if (k >= 2) check($sformatf("burst ready after pop%0d", k), 32'(w_ready[0]), 32'd1);
            check_frame(v, (k == 1) ? 4 : 0, $sformatf("burst%0d", k));
        end
        check_idle(0, "burst");
        repeat (5) @(negedge sys_clk);

        // Abort mid-frame with two words queued.
        for (int k = 0; k < 3; k++) begin
            tb_data[0]  = 9'(8'hC0 + k);
            tb_valid[0] = 1'b1;
            @(negedge sys_clk);
        end
        tb_valid[0] = 1'b0;
        repeat (43) @(negedge sys_clk);
        check("abort pre busy", 32'(w_busy[0]), 32'd1);
        #2 sys_rst_n = 1'b0;
        #1;
        check("abort tx", 32'(w_tx[0]), 32'd1);
        check("abort busy", 32'(w_busy[0]), 32'd0);
        check("abort ready", 32'(w_ready[0]), 32'd1);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        bad_idle = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge sys_clk);
            if (w_tx[0] !== 1'b1 || w_busy[0] !== 1'b0) bad_idle++;
        end
        check("post-reset idle violations", 32'(bad_idle), 32'd0);
        v = '{0, 9'h03C, 8, 0, 1'b0, 100};
        send(0, v.data, "post-reset");
        check_frame(v, 0, "post-reset");
        check_idle(0, "post-reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
